// File: rtl/elevator_ctrl.sv
// Collective (SCAN) elevator control FSM: door hold, per-floor travel timing and single-cycle
// step pulses for the elevator datapath. All outputs come straight from state registers.
module elevator_ctrl #(
  parameter int N           = 10,
  parameter int DOOR_CYCLES = 8,
  parameter int MOVE_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] floor,
  input  logic         request_i,
  input  logic         request_j_gt_i,
  input  logic         request_j_lt_i,
  input  logic         door_blocked,
  output logic         up,
  output logic         down,
  output logic         open,
  output logic         moving,
  output logic         dir_up
);

  localparam int MAX_CYCLES = (DOOR_CYCLES > MOVE_CYCLES) ? DOOR_CYCLES : MOVE_CYCLES;
  localparam int TW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [TW-1:0] DOOR_LOAD = TW'(DOOR_CYCLES - 1);
  localparam logic [TW-1:0] MOVE_LOAD = TW'(MOVE_CYCLES - 1);
  localparam logic [N-1:0]  TOP_FLOOR = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_OPEN,
    S_TRAVEL,
    S_STEP,
    S_CHECK
  } state_t;

  state_t        r_state,  w_state_nxt;
  logic [TW-1:0] r_timer,  w_timer_nxt;
  logic          r_dir_up, w_dir_up_nxt;
  logic          r_up,     w_up_nxt;
  logic          r_down,   w_down_nxt;

  logic w_ahead;
  logic w_behind;
  logic w_at_end;

  assign w_ahead  = r_dir_up ? request_j_gt_i : request_j_lt_i;
  assign w_behind = r_dir_up ? request_j_lt_i : request_j_gt_i;
  // Top-end test treats any floor code at or above the top one-hot as "at the top", so a
  // corrupted floor vector can never let the car be stepped past the shaft end.
  assign w_at_end = r_dir_up ? (floor >= TOP_FLOOR) : floor[0];

  always_comb begin
    // NOTE: every signal written here gets a default first so no path can infer a latch.
    w_state_nxt  = r_state;
    w_timer_nxt  = r_timer;
    w_dir_up_nxt = r_dir_up;
    w_up_nxt     = 1'b0;
    w_down_nxt   = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (request_i) begin
          w_state_nxt = S_OPEN;
          w_timer_nxt = DOOR_LOAD;
        end else if (w_ahead) begin
          w_state_nxt = S_TRAVEL;
          w_timer_nxt = MOVE_LOAD;
        end else if (w_behind) begin
          w_state_nxt  = S_TRAVEL;
          w_timer_nxt  = MOVE_LOAD;
          w_dir_up_nxt = ~r_dir_up;
        end
      end

      S_OPEN: begin
        if (door_blocked) begin
          w_timer_nxt = DOOR_LOAD;
        end else if (r_timer == '0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_timer_nxt = r_timer - TW'(1);
        end
      end

      S_TRAVEL: begin
        if (r_timer == '0) begin
          w_state_nxt = S_STEP;
          // Step pulse is registered on entry to STEP; at the shaft end it is replaced by a reversal.
          if (w_at_end) begin
            w_dir_up_nxt = ~r_dir_up;
          end else begin
            w_up_nxt   = r_dir_up;
            w_down_nxt = ~r_dir_up;
          end
        end else begin
          w_timer_nxt = r_timer - TW'(1);
        end
      end

      S_STEP: begin
        w_state_nxt = S_CHECK;
      end

      S_CHECK: begin
        if (request_i) begin
          w_state_nxt = S_OPEN;
          w_timer_nxt = DOOR_LOAD;
        end else if (w_ahead) begin
          w_state_nxt = S_TRAVEL;
          w_timer_nxt = MOVE_LOAD;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_timer  <= '0;
      r_dir_up <= 1'b1;
      r_up     <= 1'b0;
      r_down   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_timer  <= w_timer_nxt;
      r_dir_up <= w_dir_up_nxt;
      r_up     <= w_up_nxt;
      r_down   <= w_down_nxt;
    end
  end

  assign up     = r_up;
  assign down   = r_down;
  assign open   = (r_state == S_OPEN);
  assign moving = (r_state == S_TRAVEL) || (r_state == S_STEP);
  assign dir_up = r_dir_up;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Self-checking bench for elevator_ctrl: a datapath stand-in plus an activity-level SCAN model
// (rest / door countdown / ride segment position), directed scenarios and randomized traffic.
module tb_elevator_ctrl;

  localparam int N    = 10;
  localparam int DOOR = 8;
  localparam int MOVE = 4;

  localparam int M_REST = 0;
  localparam int M_DOOR = 1;
  localparam int M_RIDE = 2;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic [N-1:0] floor;
  logic         request_i, request_j_gt_i, request_j_lt_i;
  logic         door_blocked;
  logic         up, down, open, moving, dir_up;

  // Datapath stand-in state
  int   cur_floor;
  logic req [N];
  logic force_gt;
  bit   rand_en;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Reference model state
  int m_mode, m_left, m_pos;
  bit m_dir, m_pulse_up, m_pulse_dn;

  // Previous-cycle DUT outputs, as the datapath sees them at the next edge
  logic p_up, p_down, p_open;

  // Observation records
  int n_up, n_down;
  int up_cycles[$];
  int open_floors[$];
  int open_dirs[$];
  int open_rise_cyc[$];

  elevator_ctrl #(.N(N), .DOOR_CYCLES(DOOR), .MOVE_CYCLES(MOVE)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .floor          (floor),
    .request_i      (request_i),
    .request_j_gt_i (request_j_gt_i),
    .request_j_lt_i (request_j_lt_i),
    .door_blocked   (door_blocked),
    .up             (up),
    .down           (down),
    .open           (open),
    .moving         (moving),
    .dir_up         (dir_up)
  );

  always #5 clk = ~clk;

  always_comb begin
    floor          = '0;
    floor[cur_floor] = 1'b1;
    request_i      = 1'b0;
    request_j_gt_i = force_gt;
    request_j_lt_i = 1'b0;
    for (int f = 0; f < N; f++) begin
      if (req[f]) begin
        if (f == cur_floor)     request_i      = 1'b1;
        else if (f > cur_floor) request_j_gt_i = 1'b1;
        else                    request_j_lt_i = 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_mode     = M_REST;
    m_left     = 0;
    m_pos      = 0;
    m_dir      = 1'b1;
    m_pulse_up = 1'b0;
    m_pulse_dn = 1'b0;
  endtask

  // Advance the model across one clock edge using the inputs of the cycle that just ended.
  task automatic model_step();
    bit here, ahead, behind;
    here   = request_i;
    ahead  = m_dir ? request_j_gt_i : request_j_lt_i;
    behind = m_dir ? request_j_lt_i : request_j_gt_i;
    case (m_mode)
      M_REST: begin
        if (here) begin
          m_mode = M_DOOR; m_left = DOOR;
        end else if (ahead) begin
          m_mode = M_RIDE; m_pos = 1;
        end else if (behind) begin
          m_dir = !m_dir; m_mode = M_RIDE; m_pos = 1;
        end
      end
      M_DOOR: begin
        if (door_blocked) m_left = DOOR;
        else              m_left--;
        if (m_left == 0) m_mode = M_REST;
      end
      default: begin
        // Ride segment: positions 1..MOVE travel, MOVE+1 step, MOVE+2 arrival decision
        if (m_pos == MOVE + 2) begin
          if (here) begin
            m_mode = M_DOOR; m_left = DOOR;
          end else if (ahead) begin
            m_pos = 1;
          end else begin
            m_mode = M_REST;
          end
        end else begin
          m_pos++;
          if (m_pos == MOVE + 1) begin
            m_pulse_up = 1'b0;
            m_pulse_dn = 1'b0;
            if ((m_dir && cur_floor == N - 1) || (!m_dir && cur_floor == 0)) m_dir = !m_dir;
            else if (m_dir) m_pulse_up = 1'b1;
            else            m_pulse_dn = 1'b1;
          end
        end
      end
    endcase
  endtask

  task automatic tick();
    bit step_now;
    @(posedge clk);
    #1;
    cyc++;
    model_step();
    step_now = (m_mode == M_RIDE) && (m_pos == MOVE + 1);
    check("up",     up,     step_now && m_pulse_up);
    check("down",   down,   step_now && m_pulse_dn);
    check("open",   open,   m_mode == M_DOOR);
    check("moving", moving, (m_mode == M_RIDE) && (m_pos <= MOVE + 1));
    check("dir_up", dir_up, m_dir);
    check("up_down_excl",  up & down,    1'b0);
    check("open_mov_excl", open & moving, 1'b0);
    check("up_width",      up & p_up,    1'b0);
    check("down_width",    down & p_down, 1'b0);
    if (up) begin
      n_up++;
      up_cycles.push_back(cyc);
    end
    if (down) n_down++;
    if (open && !p_open) begin
      open_floors.push_back(cur_floor);
      open_dirs.push_back(int'(dir_up));
      open_rise_cyc.push_back(cyc);
    end
    // Datapath reacts to the previous cycle's commands
    if (p_open) req[cur_floor] = 1'b0;
    if (p_up && cur_floor < N - 1) cur_floor++;
    if (p_down && cur_floor > 0)   cur_floor--;
    if (rand_en) begin
      if ($urandom_range(0, 11) == 0) req[$urandom_range(0, N - 1)] = 1'b1;
      door_blocked = ($urandom_range(0, 15) == 0);
    end
    p_up   = up;
    p_down = down;
    p_open = open;
  endtask

  task automatic clear_records();
    n_up = 0;
    n_down = 0;
    up_cycles.delete();
    open_floors.delete();
    open_dirs.delete();
    open_rise_cyc.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_up",     up,     1'b0);
    check("rst_down",   down,   1'b0);
    check("rst_open",   open,   1'b0);
    check("rst_moving", moving, 1'b0);
    check("rst_dir",    dir_up, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    p_up   = 1'b0;
    p_down = 1'b0;
    p_open = 1'b0;
  endtask

  initial begin
    int n_open, c0;
    cur_floor    = 0;
    force_gt     = 1'b0;
    door_blocked = 1'b0;
    rand_en      = 1'b0;
    foreach (req[f]) req[f] = 1'b0;
    model_reset();
    p_up = 1'b0; p_down = 1'b0; p_open = 1'b0;
    clear_records();
    #2;
    do_reset();

    // 1: request at current floor opens next cycle, held exactly DOOR cycles
    cur_floor = 1;
    req[1] = 1'b1;
    tick();
    check("t1_open_next", open, 1'b1);
    n_open = 1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (open) n_open++;
    end
    check("t1_open_len", n_open, DOOR);

    // 2: floor 1 -> 4, step pulses MOVE+1 after flag then every MOVE+2
    clear_records();
    req[4] = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 40; i++) tick();
    check("t2_up_count", up_cycles.size(), 3);
    if (up_cycles.size() >= 3) begin
      check("t2_first_up", up_cycles[0] - c0, MOVE + 1);
      check("t2_up_gap1",  up_cycles[1] - up_cycles[0], MOVE + 2);
      check("t2_up_gap2",  up_cycles[2] - up_cycles[1], MOVE + 2);
      check("t2_open_at_check", open_rise_cyc.size() > 0 ? open_rise_cyc[0] - up_cycles[2] : -1, 2);
    end
    check("t2_down_count", n_down, 0);
    check("t2_floor", cur_floor, 4);

    // 3: park at 5 going up, then requests at 8 and 2
    req[5] = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    check("t3_at5", cur_floor, 5);
    clear_records();
    req[8] = 1'b1;
    req[2] = 1'b1;
    for (int i = 0; i < 120; i++) tick();
    check("t3_stops", open_floors.size(), 2);
    if (open_floors.size() >= 2) begin
      check("t3_first_stop",  open_floors[0], 8);
      check("t3_second_stop", open_floors[1], 2);
      check("t3_dir_at_2",    open_dirs[1], 0);
    end
    check("t3_up_count",   n_up, 3);
    check("t3_down_count", n_down, 6);

    // 4: door blocked for 20 cycles from the first open cycle
    req[2] = 1'b1;
    tick();
    check("t4_open", open, 1'b1);
    door_blocked = 1'b1;
    n_open = 1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (open) n_open++;
      if (i == 20) door_blocked = 1'b0;
    end
    check("t4_open_len", n_open, 20 + DOOR);

    // 5: top floor with a forced "above" flag: no pulse, direction reverses
    foreach (req[f]) req[f] = 1'b0;
    cur_floor = N - 1;
    force_gt  = 1'b1;
    do_reset();
    clear_records();
    for (int i = 0; i < 5; i++) tick();
    check("t5_step_moving", moving, 1'b1);
    check("t5_no_up",       up, 1'b0);
    check("t5_dir_flip",    dir_up, 1'b0);
    tick();
    force_gt = 1'b0;
    check("t5_dir_after", dir_up, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    check("t5_floor", cur_floor, N - 1);

    // 6: asynchronous reset while travelling down
    req[3] = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("t6_travelling", moving, 1'b1);
    #2;
    foreach (req[f]) req[f] = 1'b0;
    do_reset();
    clear_records();
    for (int i = 0; i < 20; i++) tick();
    check("t6_no_up",   n_up, 0);
    check("t6_no_down", n_down, 0);
    check("t6_dir",     dir_up, 1'b1);

    // Randomized traffic and door obstruction
    rand_en = 1'b1;
    for (int i = 0; i < 3000; i++) tick();
    rand_en = 1'b0;
    door_blocked = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
